// File: rtl/maj_adder_pkg.sv
// Shared types and helpers for the majority-logic serial adder.
package maj_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Three-input majority vote, the only gate the adder columns are built from.
  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/maj_full_adder.sv
// Single-column full adder built purely from majority gates.
module maj_full_adder
  import maj_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Carry is the plain majority; sum reuses the carry so no XOR is needed.
  always_comb begin
    cout = maj(a, b, cin);
    sum  = maj(~cout, cin, maj(a, b, ~cin));
  end

endmodule

// File: rtl/maj_serial_adder.sv
// Chunk-serial add/subtract unit: BPC bits per cycle through a majority
// full-adder chain, carry held in a register between chunks.
module maj_serial_adder
  import maj_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int N     = WIDTH / BPC;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  generate
    if (WIDTH < 2 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_bad_params
      $error("maj_serial_adder: WIDTH must be >= 2 and a multiple of BPC");
    end
  endgenerate

  state_t state, state_next;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_reg, b_reg, acc, acc_next;
  logic             carry_reg;
  logic [BPC-1:0]   chunk_a, chunk_b, chunk_sum;
  logic [BPC:0]     chain;
  logic             last_chunk;

  assign last_chunk = (cnt == LAST);
  assign chain[0]   = carry_reg;

  generate
    for (genvar i = 0; i < BPC; i++) begin : g_col
      maj_full_adder u_fa (
        .a    (chunk_a[i]),
        .b    (chunk_b[i]),
        .cin  (chain[i]),
        .sum  (chunk_sum[i]),
        .cout (chain[i+1])
      );
    end
  endgenerate

  // Select the current chunk of each operand and merge its sum into the accumulator.
  always_comb begin
    chunk_a  = a_reg[int'(cnt) * BPC +: BPC];
    chunk_b  = b_reg[int'(cnt) * BPC +: BPC];
    acc_next = acc;
    acc_next[int'(cnt) * BPC +: BPC] = chunk_sum;
  end

  // State register; reset always lands in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept, walk N chunks, then wait for the consumer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = BUSY;
      BUSY:    if (last_chunk) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state; reset masks in_ready immediately.
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
  end

  // Datapath: subtract is done as A + ~B + ~borrow, so B and the carry-in are
  // inverted once at capture and the columns only ever add.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      carry_reg <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      cnt       <= '0;
      a_reg     <= in_a;
      b_reg     <= (in_op == OP_SUB) ? ~in_b : in_b;
      carry_reg <= (in_op == OP_SUB) ? ~in_cin : in_cin;
      acc       <= '0;
    end else if (state == BUSY) begin
      acc       <= acc_next;
      carry_reg <= chain[BPC];
      if (last_chunk) begin
        out_sum  <= acc_next;
        out_cout <= chain[BPC];
        out_ovf  <= chain[BPC] ^ chain[BPC-1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
